block_accumulator: RTL

Downstream consumer of the multiplier's block-read port. When the multiplier reports ready, it issues a single block-read request, then collects the DEPTH product words streamed on VALID_memVal/memVal_data. It reduces them to a full-precision sum, plus an optional maximum and its index. The result is held behind a valid/ack handshake for the next stage and is protected by a stall timeout.

---
 rtl/block_accumulator.sv | 127 ++++++++++++
 1 files changed

// File: rtl/block_accumulator.sv
// Block-read consumer: requests one block from the multiplier and reduces DEPTH beats to sum/beats/err.
// Optional max/index tracking is compiled in when BLOCK_ACC_MAX_EN is defined.
module block_accumulator #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 64,
    parameter int TIMEOUT   = 16,
    parameter int ACC_WIDTH = WIDTH + $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   RDY_mult,
    output logic                   EN_blockRead,
    input  logic                   VALID_memVal,
    input  logic [WIDTH-1:0]       memVal_data,
    output logic                   VALID_sum,
    input  logic                   ACK_sum,
    output logic [ACC_WIDTH-1:0]   sum_out,
    output logic [WIDTH-1:0]       max_out,
    output logic [5:0]             max_idx,
    output logic [$clog2(DEPTH):0] beats,
    output logic                   err,
    output logic                   busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]     r_beats;
    logic [TMO_W-1:0]     r_tmo;
    logic                 r_err;

    logic w_clear;
    logic w_beat;
    logic w_last;
    logic w_expire;

    assign w_clear  = (r_state == S_REQ);
    assign w_beat   = (r_state == S_COLLECT) && VALID_memVal;
    assign w_last   = w_beat && (r_beats == CNT_W'(DEPTH - 1));
    // Expiry fires on the TIMEOUT-th consecutive idle cycle (counter holds TIMEOUT-1 before it).
    assign w_expire = (r_state == S_COLLECT) && !VALID_memVal &&
                      (r_tmo == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start && RDY_mult) w_next = S_REQ;
            S_REQ:     w_next = S_COLLECT;
            S_COLLECT: if (w_last || w_expire) w_next = S_DONE;
            S_DONE:    if (ACK_sum) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_beats <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else if (w_clear) begin
            r_acc   <= '0;
            r_beats <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else if (w_beat) begin
            r_acc   <= r_acc + ACC_WIDTH'(memVal_data);
            r_beats <= r_beats + CNT_W'(1);
            r_tmo   <= '0;
        end else if (r_state == S_COLLECT) begin
            r_tmo <= r_tmo + TMO_W'(1);
            if (w_expire) r_err <= 1'b1;
        end
    end

`ifdef BLOCK_ACC_MAX_EN
    logic [WIDTH-1:0] r_max;
    logic [5:0]       r_max_idx;

    // Strict compare so ties keep the earliest index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max     <= '0;
            r_max_idx <= '0;
        end else if (w_clear) begin
            r_max     <= '0;
            r_max_idx <= '0;
        end else if (w_beat && (memVal_data > r_max)) begin
            r_max     <= memVal_data;
            r_max_idx <= 6'(r_beats);
        end
    end

    assign max_out = r_max;
    assign max_idx = r_max_idx;
`else
    assign max_out = '0;
    assign max_idx = '0;
`endif

    assign EN_blockRead = (r_state == S_REQ);
    assign VALID_sum    = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign sum_out      = r_acc;
    assign beats        = r_beats;
    assign err          = r_err;

endmodule
